// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the basic-gate sweep checker.
// Holds the FSM state encoding and the bit positions of the gate results.
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int RES_W    = 5;
    localparam int RES_NOT  = 0;
    localparam int RES_NAND = 1;
    localparam int RES_AND  = 2;
    localparam int RES_OR   = 3;
    localparam int RES_XOR  = 4;

    localparam logic [7:0] ERR_MAX = 8'hFF;

endpackage

// File: rtl/gate_sweep_checker_golden.sv
// Combinational reference model of the five basic gates for one (a,b) vector.
// Standalone so test benches can reuse the same expected values.
module gate_golden
    import gate_sweep_pkg::*;
(
    input  logic             a,
    input  logic             b,
    output logic [RES_W-1:0] expected
);

    always_comb begin
        expected           = '0;
        expected[RES_NOT]  = ~a;
        expected[RES_NAND] = ~(a & b);
        expected[RES_AND]  = a & b;
        expected[RES_OR]   = a | b;
        expected[RES_XOR]  = a ^ b;
    end

endmodule

// File: rtl/gate_sweep_checker.sv
// Clocked self-test: sweeps (a,b) through all four vectors PASSES times, waits
// SETTLE_CYCLES per vector, then compares the gate outputs to the golden model.
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int PASSES        = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [RES_W-1:0] res,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_count,
    output logic             fail_seen,
    output logic [1:0]       first_fail_vec,
    output logic [RES_W-1:0] first_fail_mask
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] PASS_LAST   = 8'(PASSES - 1);

    state_t             state_reg, state_next;
    logic [1:0]         vec_reg, vec_next;
    logic [7:0]         pass_cnt_reg, pass_cnt_next;
    logic [3:0]         settle_reg, settle_next;
    logic               a_reg, a_next;
    logic               b_reg, b_next;
    logic [7:0]         err_reg, err_next;
    logic               fail_seen_reg, fail_seen_next;
    logic [1:0]         ffv_reg, ffv_next;
    logic [RES_W-1:0]   ffm_reg, ffm_next;

    logic [RES_W-1:0]   expected;
    logic [RES_W-1:0]   mismatch_mask;
    logic               mismatch;
    logic [1:0]         vec_inc;

    // Expected values come from the registered stimulus, not the next vector.
    gate_golden u_golden (
        .a        (a_reg),
        .b        (b_reg),
        .expected (expected)
    );

    genvar gi;
    generate
        for (gi = 0; gi < RES_W; gi++) begin : g_cmp
            assign mismatch_mask[gi] = res[gi] ^ expected[gi];
        end
    endgenerate

    assign mismatch = |mismatch_mask;
    assign vec_inc  = vec_reg + 2'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vec_reg       <= '0;
            pass_cnt_reg  <= '0;
            settle_reg    <= '0;
            a_reg         <= 1'b0;
            b_reg         <= 1'b0;
            err_reg       <= '0;
            fail_seen_reg <= 1'b0;
            ffv_reg       <= '0;
            ffm_reg       <= '0;
        end else begin
            vec_reg       <= vec_next;
            pass_cnt_reg  <= pass_cnt_next;
            settle_reg    <= settle_next;
            a_reg         <= a_next;
            b_reg         <= b_next;
            err_reg       <= err_next;
            fail_seen_reg <= fail_seen_next;
            ffv_reg       <= ffv_next;
            ffm_reg       <= ffm_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        vec_next       = vec_reg;
        pass_cnt_next  = pass_cnt_reg;
        settle_next    = settle_reg;
        a_next         = a_reg;
        b_next         = b_reg;
        err_next       = err_reg;
        fail_seen_next = fail_seen_reg;
        ffv_next       = ffv_reg;
        ffm_next       = ffm_reg;

        busy = (state_reg == DRIVE) || (state_reg == CHECK);
        done = (state_reg == DONE);
        pass = (state_reg == DONE) && (err_reg == 8'd0);

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next     = DRIVE;
                    vec_next       = '0;
                    pass_cnt_next  = '0;
                    settle_next    = '0;
                    a_next         = 1'b0;
                    b_next         = 1'b0;
                    err_next       = '0;
                    fail_seen_next = 1'b0;
                    ffv_next       = '0;
                    ffm_next       = '0;
                end
            end
            DRIVE: begin
                if (settle_reg == SETTLE_LAST) begin
                    state_next  = CHECK;
                    settle_next = '0;
                end else begin
                    settle_next = settle_reg + 4'd1;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    if (err_reg != ERR_MAX) begin
                        err_next = err_reg + 8'd1;
                    end
                    if (!fail_seen_reg) begin
                        fail_seen_next = 1'b1;
                        ffv_next       = {b_reg, a_reg};
                        ffm_next       = mismatch_mask;
                    end
                end
                if ((vec_reg == 2'd3) && (pass_cnt_reg == PASS_LAST)) begin
                    state_next = DONE;
                    a_next     = 1'b0;
                    b_next     = 1'b0;
                end else begin
                    state_next = DRIVE;
                    vec_next   = vec_inc;
                    a_next     = vec_inc[0];
                    b_next     = vec_inc[1];
                    if (vec_reg == 2'd3) begin
                        pass_cnt_next = pass_cnt_reg + 8'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign a               = a_reg;
    assign b               = b_reg;
    assign err_count       = err_reg;
    assign fail_seen       = fail_seen_reg;
    assign first_fail_vec  = ffv_reg;
    assign first_fail_mask = ffm_reg;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench: four checker instances with good and faulty gate models,
// driven from one linear initial block and checked with immediate assertions.
module tb_gate_sweep_checker;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // ok: real gates, defaults
    logic       rst_ok, st_ok, a_ok, b_ok, busy_ok, done_ok, pass_ok, fs_ok;
    logic [4:0] res_ok, ffm_ok;
    logic [7:0] err_ok;
    logic [1:0] ffv_ok;
    assign res_ok = {a_ok ^ b_ok, a_ok | b_ok, a_ok & b_ok, ~(a_ok & b_ok), ~a_ok};

    // x1: xor stuck at 0, PASSES=1
    logic       rst_x1, st_x1, a_x1, b_x1, busy_x1, done_x1, pass_x1, fs_x1;
    logic [4:0] res_x1, ffm_x1;
    logic [7:0] err_x1;
    logic [1:0] ffv_x1;
    assign res_x1 = {1'b0, a_x1 | b_x1, a_x1 & b_x1, ~(a_x1 & b_x1), ~a_x1};

    // x3: xor stuck at 0, PASSES=3, SETTLE_CYCLES=3
    logic       rst_x3, st_x3, a_x3, b_x3, busy_x3, done_x3, pass_x3, fs_x3;
    logic [4:0] res_x3, ffm_x3;
    logic [7:0] err_x3;
    logic [1:0] ffv_x3;
    assign res_x3 = {1'b0, a_x3 | b_x3, a_x3 & b_x3, ~(a_x3 & b_x3), ~a_x3};

    // nt: inverted Not output, PASSES=100
    logic       rst_nt, st_nt, a_nt, b_nt, busy_nt, done_nt, pass_nt, fs_nt;
    logic [4:0] res_nt, ffm_nt;
    logic [7:0] err_nt;
    logic [1:0] ffv_nt;
    assign res_nt = {a_nt ^ b_nt, a_nt | b_nt, a_nt & b_nt, ~(a_nt & b_nt), a_nt};

    gate_sweep_checker u_ok (
        .clock(clock), .reset(rst_ok), .start(st_ok), .res(res_ok),
        .a(a_ok), .b(b_ok), .busy(busy_ok), .done(done_ok), .pass(pass_ok),
        .err_count(err_ok), .fail_seen(fs_ok),
        .first_fail_vec(ffv_ok), .first_fail_mask(ffm_ok)
    );

    gate_sweep_checker #(.SETTLE_CYCLES(1), .PASSES(1)) u_x1 (
        .clock(clock), .reset(rst_x1), .start(st_x1), .res(res_x1),
        .a(a_x1), .b(b_x1), .busy(busy_x1), .done(done_x1), .pass(pass_x1),
        .err_count(err_x1), .fail_seen(fs_x1),
        .first_fail_vec(ffv_x1), .first_fail_mask(ffm_x1)
    );

    gate_sweep_checker #(.SETTLE_CYCLES(3), .PASSES(3)) u_x3 (
        .clock(clock), .reset(rst_x3), .start(st_x3), .res(res_x3),
        .a(a_x3), .b(b_x3), .busy(busy_x3), .done(done_x3), .pass(pass_x3),
        .err_count(err_x3), .fail_seen(fs_x3),
        .first_fail_vec(ffv_x3), .first_fail_mask(ffm_x3)
    );

    gate_sweep_checker #(.SETTLE_CYCLES(1), .PASSES(100)) u_nt (
        .clock(clock), .reset(rst_nt), .start(st_nt), .res(res_nt),
        .a(a_nt), .b(b_nt), .busy(busy_nt), .done(done_nt), .pass(pass_nt),
        .err_count(err_nt), .fail_seen(fs_nt),
        .first_fail_vec(ffv_nt), .first_fail_mask(ffm_nt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        rst_ok = 1'b1; rst_x1 = 1'b1; rst_x3 = 1'b1; rst_nt = 1'b1;
        st_ok  = 1'b0; st_x1  = 1'b0; st_x3  = 1'b0; st_nt  = 1'b0;
        step(2);
        chk("rst_a",    {31'd0, a_ok},    32'd0);
        chk("rst_b",    {31'd0, b_ok},    32'd0);
        chk("rst_busy", {31'd0, busy_ok}, 32'd0);
        chk("rst_done", {31'd0, done_ok}, 32'd0);
        chk("rst_pass", {31'd0, pass_ok}, 32'd0);
        chk("rst_err",  {24'd0, err_ok},  32'd0);
        chk("rst_fs",   {31'd0, fs_ok},   32'd0);
        chk("rst_ffv",  {30'd0, ffv_ok},  32'd0);
        chk("rst_ffm",  {27'd0, ffm_ok},  32'd0);
        rst_ok = 1'b0; rst_x1 = 1'b0; rst_x3 = 1'b0; rst_nt = 1'b0;
        step(1);

        // clean sweep: a/b sequence 00,10,01,11, two cycles each
        st_ok = 1'b1; step(1); st_ok = 1'b0;
        chk("ok_busy0", {31'd0, busy_ok}, 32'd1);
        chk("ok_v0",    {30'd0, a_ok, b_ok}, 32'b00);
        step(1);
        chk("ok_v0h",   {30'd0, a_ok, b_ok}, 32'b00);
        step(1);
        chk("ok_v1",    {30'd0, a_ok, b_ok}, 32'b10);
        step(2);
        chk("ok_v2",    {30'd0, a_ok, b_ok}, 32'b01);
        step(2);
        chk("ok_v3",    {30'd0, a_ok, b_ok}, 32'b11);
        chk("ok_done7", {31'd0, done_ok}, 32'd0);
        step(2);
        chk("ok_done",  {31'd0, done_ok}, 32'd1);
        chk("ok_busy",  {31'd0, busy_ok}, 32'd0);
        chk("ok_pass",  {31'd0, pass_ok}, 32'd1);
        chk("ok_err",   {24'd0, err_ok},  32'd0);
        chk("ok_fs",    {31'd0, fs_ok},   32'd0);
        chk("ok_ab_done", {30'd0, a_ok, b_ok}, 32'b00);

        // xor stuck-at-0, single pass
        st_x1 = 1'b1; step(1); st_x1 = 1'b0;
        step(4);
        chk("x1_err_mid", {24'd0, err_x1}, 32'd1);
        chk("x1_fs_mid",  {31'd0, fs_x1},  32'd1);
        step(4);
        chk("x1_done", {31'd0, done_x1}, 32'd1);
        chk("x1_err",  {24'd0, err_x1},  32'd2);
        chk("x1_pass", {31'd0, pass_x1}, 32'd0);
        chk("x1_ffv",  {30'd0, ffv_x1},  32'b01);
        chk("x1_ffm",  {27'd0, ffm_x1},  32'b10000);

        // xor stuck-at-0, 3 passes, 3 settle cycles: 48-cycle run
        st_x3 = 1'b1; step(1); st_x3 = 1'b0;
        step(47);
        chk("x3_done47", {31'd0, done_x3}, 32'd0);
        chk("x3_busy47", {31'd0, busy_x3}, 32'd1);
        step(1);
        chk("x3_done", {31'd0, done_x3}, 32'd1);
        chk("x3_err",  {24'd0, err_x3},  32'd6);
        chk("x3_ffv",  {30'd0, ffv_x3},  32'b01);

        // inverted Not, 100 passes: 400 failures saturate at 255
        st_nt = 1'b1; step(1); st_nt = 1'b0;
        step(799);
        chk("nt_done799", {31'd0, done_nt}, 32'd0);
        step(1);
        chk("nt_done", {31'd0, done_nt}, 32'd1);
        chk("nt_err",  {24'd0, err_nt},  32'd255);
        chk("nt_pass", {31'd0, pass_nt}, 32'd0);
        chk("nt_ffv",  {30'd0, ffv_nt},  32'b00);
        chk("nt_ffm",  {27'd0, ffm_nt},  32'b00001);

        // abort during vector 2, reset beating start on the same edge
        st_ok = 1'b1; step(1); st_ok = 1'b0;
        step(4);
        chk("ab_v2", {30'd0, a_ok, b_ok}, 32'b01);
        rst_ok = 1'b1; st_ok = 1'b1; step(1);
        rst_ok = 1'b0; st_ok = 1'b0;
        chk("ab_busy", {31'd0, busy_ok}, 32'd0);
        chk("ab_done", {31'd0, done_ok}, 32'd0);
        chk("ab_ab",   {30'd0, a_ok, b_ok}, 32'b00);
        chk("ab_err",  {24'd0, err_ok}, 32'd0);
        step(1);
        chk("ab_idle", {31'd0, busy_ok}, 32'd0);
        st_ok = 1'b1; step(1); st_ok = 1'b0;
        step(8);
        chk("ab_rerun_done", {31'd0, done_ok}, 32'd1);
        chk("ab_rerun_pass", {31'd0, pass_ok}, 32'd1);

        // start held high: restart from DONE clears errors, no restart mid-run
        st_x1 = 1'b1; step(1);
        chk("sh_busy",  {31'd0, busy_x1}, 32'd1);
        chk("sh_err0",  {24'd0, err_x1},  32'd0);
        chk("sh_fs0",   {31'd0, fs_x1},   32'd0);
        step(4);
        chk("sh_v2",    {30'd0, a_x1, b_x1}, 32'b01);
        chk("sh_err1",  {24'd0, err_x1},  32'd1);
        step(4);
        chk("sh_done",  {31'd0, done_x1}, 32'd1);
        chk("sh_err2",  {24'd0, err_x1},  32'd2);
        step(1);
        chk("sh_rest_busy", {31'd0, busy_x1}, 32'd1);
        chk("sh_rest_done", {31'd0, done_x1}, 32'd0);
        chk("sh_rest_err",  {24'd0, err_x1},  32'd0);
        st_x1 = 1'b0;
        step(8);
        chk("sh_final_done", {31'd0, done_x1}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
